gcd_requester: RTL and testbench

- Front-end sequencer that feeds the gcd core. It accepts operand pairs on a valid/ready stream, drives the core's opa/opb/start inputs, and waits for done. It then captures the result into a small output FIFO that is drained on a valid/ready result stream.
- Zero operands are handled locally without starting the core.
- A watchdog counter guards against a core that never asserts done.

---
 rtl/gcd_requester.sv | 199 +++++++++++++++++++
 tb/tb_gcd_requester.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_requester.sv
// ---------------------------------------------------------------------------
// gcd_requester
//
// Front-end sequencer for the gcd core. It takes operand pairs from a
// valid/ready stream, hands them to the core and waits for the core's done.
// Results go into a small output FIFO that a consumer drains on a
// valid/ready result stream. A pair with a zero operand is answered here
// without starting the core. A watchdog counter aborts a core that never
// raises done, and pushes an error entry instead.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset (0 = in reset)
//   in_valid   operand pair valid
//   in_ready   pair accepted on an edge where in_valid & in_ready
//   in_a/in_b  operands A and B
//   opa/opb    operands driven to the core, held stable while it works
//   start      one-cycle start pulse to the core
//   result     gcd value from the core, valid while done is high
//   done       core completion flag
//   out_valid  output FIFO non-empty
//   out_ready  consumer pops the head on an edge where out_valid & out_ready
//   out_data   head-of-FIFO gcd value
//   out_err    head entry was produced by a watchdog timeout
//   busy       sequencer is not idle
// ---------------------------------------------------------------------------
module gcd_requester #(
    parameter int W       = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] opa,
    output logic [W-1:0] opb,
    output logic         start,
    input  logic [W-1:0] result,
    input  logic         done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic         busy
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(DEPTH);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [W-1:0]    r_opa;
    logic [W-1:0]    r_opb;
    logic [TW-1:0]   r_tmo;
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CNTW-1:0] r_count;
    logic [W-1:0]    r_memData [DEPTH];
    logic            r_memErr  [DEPTH];

    logic            w_inReady;
    logic            w_accept;
    logic            w_bypass;
    logic            w_corePush;
    logic            w_tmoPush;
    logic            w_push;
    logic            w_pop;
    logic            w_outValid;
    logic [W-1:0]    w_pushData;
    logic            w_pushErr;
    logic [1:0]      w_nextState;

    // Readiness comes only from registered state, so it never loops back
    // through in_valid. Holding it low while reset is asserted keeps
    // upstream from handing over a pair that would be lost. Because only
    // one pair is outstanding and FIFO room is checked here, a later core
    // result always finds a free slot.
    assign w_inReady  = reset & (r_state == S_IDLE) & (r_count < FIFO_FULL);
    assign w_accept   = in_valid & w_inReady;
    assign w_bypass   = w_accept & ((in_a == '0) | (in_b == '0));
    assign w_corePush = (r_state == S_WAIT) & done;
    assign w_tmoPush  = (r_state == S_WAIT) & ~done & (r_tmo == TMO_LAST);
    assign w_push     = w_bypass | w_corePush | w_tmoPush;
    assign w_outValid = (r_count != '0);
    assign w_pop      = w_outValid & out_ready;

    // A zero operand makes the gcd equal to the other operand, and
    // gcd(0,0) is 0, so OR-ing the pair gives the answer directly.
    // A timeout entry carries a zero value with the error flag set.
    always_comb begin
        w_pushData = '0;
        w_pushErr  = 1'b0;
        if (w_bypass) begin
            w_pushData = in_a | in_b;
        end else if (w_corePush) begin
            w_pushData = result;
        end else if (w_tmoPush) begin
            w_pushErr = 1'b1;
        end
    end

    // Sequencer next state. done outside WAIT is ignored; in WAIT a done
    // on the same edge as the timeout wins because both exits go to IDLE
    // and the push selection above prefers the core result.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_bypass) begin
                    w_nextState = S_START;
                end
            end
            S_START: begin
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (w_corePush || w_tmoPush) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State, latched operands and the watchdog counter. The counter is
    // cleared while start is high and holds its value when WAIT exits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept && !w_bypass) begin
                r_opa <= in_a;
                r_opb <= in_b;
            end
            if (r_state == S_START) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT && !w_corePush && !w_tmoPush) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    // FIFO pointers and occupancy. A push and pop on the same edge leave
    // the count unchanged, even when the FIFO is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage needs no reset: the outputs are masked while the FIFO
    // is empty, and nothing is pushed while reset is asserted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memData[r_wrPtr] <= w_pushData;
            r_memErr[r_wrPtr]  <= w_pushErr;
        end
    end

    assign in_ready  = w_inReady;
    assign opa       = r_opa;
    assign opb       = r_opb;
    assign start     = (r_state == S_START);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = w_outValid;
    assign out_data  = w_outValid ? r_memData[r_rdPtr] : '0;
    assign out_err   = w_outValid ? r_memErr[r_rdPtr] : 1'b0;

endmodule

// File: tb/tb_gcd_requester.sv
// ---------------------------------------------------------------------------
// tb_gcd_requester
//
// Self-checking bench for gcd_requester. A behavioural gcd core answers
// start pulses after a programmable delay, or can be told to hang or be
// replaced by hand-driven done/result for the corner cases. A table of
// operand pairs with hand-computed results and latencies covers the main
// path; short hand-written sequences cover backpressure, timeout, the
// done/timeout tie, stray done and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_gcd_requester;

    localparam int W       = 32;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         start;
    logic [W-1:0] result;
    logic         done;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         busy;

    logic         modelDone    = 1'b0;
    logic         manualDone   = 1'b0;
    logic [W-1:0] modelResult  = '0;
    logic [W-1:0] manualResult = '0;
    bit           coreManual   = 1'b0;
    bit           coreHang     = 1'b0;
    int           coreLatency  = 5;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expData;
        int           expLat;
        int           expStarts;
    } vec_t;

    vec_t vecs [11];

    assign done   = modelDone | manualDone;
    assign result = coreManual ? manualResult : modelResult;

    gcd_requester #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .opa       (opa),
        .opb       (opb),
        .start     (start),
        .result    (result),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [W-1:0] refGcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: when start is seen, raise done for one cycle
    // coreLatency cycles later with the gcd of the latched operands.
    initial begin : coreModel
        int           cnt;
        logic [W-1:0] la;
        logic [W-1:0] lb;
        cnt = -1;
        la  = '0;
        lb  = '0;
        forever begin
            @(posedge clk);
            #1;
            modelDone = 1'b0;
            if (reset == 1'b0) begin
                cnt = -1;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        modelDone   = 1'b1;
                        modelResult = refGcd(la, lb);
                        cnt         = -1;
                    end
                end
                if (start && !coreManual && !coreHang) begin
                    la  = opa;
                    lb  = opb;
                    cnt = coreLatency;
                end
            end
        end
    end

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then present the pair for exactly one
    // accepting edge. Returns one time unit after that edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        waited = 0;
        while (!in_ready && waited < 100) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_budget", 32'd0, 32'd1);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid, recording start
    // pulses and whether opa/opb stayed at the accepted pair while busy.
    task automatic waitOutput(input int budget, input logic [W-1:0] a, input logic [W-1:0] b,
                              output int lat, output int starts, output bit opsStable);
        lat       = -1;
        starts    = 0;
        opsStable = 1'b1;
        for (int j = 0; j < budget; j++) begin
            if (start) starts++;
            if (out_valid) begin
                lat = j;
                break;
            end
            if (busy && (opa !== a || opb !== b)) opsStable = 1'b0;
            step();
        end
        if (lat < 0) begin
            checkOutput("output_budget", 32'd0, 32'd1);
        end
    endtask

    task automatic waitIdle(input int budget);
        int waited;
        waited = 0;
        while (busy && waited < budget) begin
            step();
            waited++;
        end
        if (busy) begin
            checkOutput("idle_budget", 32'd0, 32'd1);
        end
    endtask

    initial begin : mainTest
        int           lat;
        int           starts;
        bit           opsStable;
        logic [W-1:0] bpA   [3];
        logic [W-1:0] bpB   [3];
        logic [W-1:0] bpExp [3];

        vecs[0]  = '{32'd1071,       32'd462,        32'd21,         6, 1};
        vecs[1]  = '{32'd0,          32'd35,         32'd35,         0, 0};
        vecs[2]  = '{32'd48,         32'd0,          32'd48,         0, 0};
        vecs[3]  = '{32'd0,          32'd0,          32'd0,          0, 0};
        vecs[4]  = '{32'd12,         32'd18,         32'd6,          6, 1};
        vecs[5]  = '{32'd35,         32'd14,         32'd7,          6, 1};
        vecs[6]  = '{32'd17,         32'd5,          32'd1,          6, 1};
        vecs[7]  = '{32'd100,        32'd100,        32'd100,        6, 1};
        vecs[8]  = '{32'hFFFF_FFFF,  32'd5,          32'd5,          6, 1};
        vecs[9]  = '{32'd1,          32'd1,          32'd1,          6, 1};
        vecs[10] = '{32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0};

        bpA[0] = 32'd0;  bpB[0] = 32'd35; bpExp[0] = 32'd35;
        bpA[1] = 32'd48; bpB[1] = 32'd0;  bpExp[1] = 32'd48;
        bpA[2] = 32'd0;  bpB[2] = 32'd0;  bpExp[2] = 32'd0;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset held for three cycles; every output sits at its reset value.
        step();
        step();
        step();
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy},      32'd0);
        checkOutput("rst_start",     {31'd0, start},     32'd0);
        checkOutput("rst_out_data",  out_data,           32'd0);
        checkOutput("rst_out_err",   {31'd0, out_err},   32'd0);
        checkOutput("rst_opa",       opa,                32'd0);
        checkOutput("rst_opb",       opb,                32'd0);
        #2 reset = 1'b1;
        step();
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven vectors with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            waitOutput(40, vecs[i].a, vecs[i].b, lat, starts, opsStable);
            checkOutput($sformatf("vec%0d_data", i),   out_data,           vecs[i].expData);
            checkOutput($sformatf("vec%0d_err", i),    {31'd0, out_err},   32'd0);
            checkOutput($sformatf("vec%0d_lat", i),    W'(lat),            W'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d_starts", i), W'(starts),         W'(vecs[i].expStarts));
            checkOutput($sformatf("vec%0d_ops", i),    {31'd0, opsStable}, 32'd1);
            step();
            checkOutput($sformatf("vec%0d_popped", i), {31'd0, out_valid}, 32'd0);
            checkOutput($sformatf("vec%0d_idle", i),   {31'd0, busy},      32'd0);
        end

        // Back-to-back bypass pairs: each result visible right after its
        // accept edge while the previous one pops on the same edge.
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("b2b%0d_ready", i), {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_a     = bpA[i];
            in_b     = bpB[i];
            step();
            checkOutput($sformatf("b2b%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("b2b%0d_data", i),  out_data,           bpExp[i]);
            checkOutput($sformatf("b2b%0d_start", i), {31'd0, start},     32'd0);
        end
        in_valid = 1'b0;
        step();
        checkOutput("b2b_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill both FIFO slots, a third pair must wait.
        out_ready = 1'b0;
        applyStimulus(32'd12, 32'd18);
        waitIdle(40);
        applyStimulus(32'd35, 32'd14);
        waitIdle(40);
        checkOutput("bp_head6",       out_data,           32'd6);
        checkOutput("bp_full_ready",  {31'd0, in_ready},  32'd0);
        in_valid = 1'b1;
        in_a     = 32'd9;
        in_b     = 32'd3;
        step();
        checkOutput("bp_hold_busy",   {31'd0, busy},      32'd0);
        checkOutput("bp_hold_ready",  {31'd0, in_ready},  32'd0);
        step();
        checkOutput("bp_hold_head",   out_data,           32'd6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("bp_head7",       out_data,           32'd7);
        checkOutput("bp_ready_again", {31'd0, in_ready},  32'd1);
        step();
        in_valid = 1'b0;
        checkOutput("bp_accept_busy", {31'd0, busy},      32'd1);
        waitIdle(40);
        checkOutput("bp_still7",      out_data,           32'd7);
        out_ready = 1'b1;
        step();
        checkOutput("bp_head3",       out_data,           32'd3);
        checkOutput("bp_head3_valid", {31'd0, out_valid}, 32'd1);
        step();
        checkOutput("bp_empty",       {31'd0, out_valid}, 32'd0);

        // Timeout: the core never answers; an error entry appears 16
        // cycles after WAIT is entered (17 after the accept edge).
        out_ready = 1'b0;
        coreHang  = 1'b1;
        applyStimulus(32'd10, 32'd4);
        waitOutput(60, 32'd10, 32'd4, lat, starts, opsStable);
        checkOutput("tmo_lat",    W'(lat),            32'd17);
        checkOutput("tmo_starts", W'(starts),         32'd1);
        checkOutput("tmo_data",   out_data,           32'd0);
        checkOutput("tmo_err",    {31'd0, out_err},   32'd1);
        checkOutput("tmo_idle",   {31'd0, busy},      32'd0);
        out_ready = 1'b1;
        step();
        checkOutput("tmo_popped", {31'd0, out_valid}, 32'd0);
        coreHang = 1'b0;
        applyStimulus(32'd9, 32'd6);
        waitOutput(40, 32'd9, 32'd6, lat, starts, opsStable);
        checkOutput("after_tmo_data", out_data,         32'd3);
        checkOutput("after_tmo_err",  {31'd0, out_err}, 32'd0);
        checkOutput("after_tmo_lat",  W'(lat),          32'd6);
        step();

        // Stray done while idle must not push anything.
        out_ready    = 1'b0;
        coreManual   = 1'b1;
        manualDone   = 1'b1;
        manualResult = 32'd99;
        step();
        manualDone = 1'b0;
        checkOutput("stray_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("stray_busy",  {31'd0, busy},      32'd0);
        step();
        checkOutput("stray_valid2", {31'd0, out_valid}, 32'd0);

        // done on the very edge where the watchdog would fire: done wins.
        applyStimulus(32'd8, 32'd12);
        for (int j = 0; j < 16; j++) step();
        checkOutput("tie_pre_busy",  {31'd0, busy},      32'd1);
        checkOutput("tie_pre_valid", {31'd0, out_valid}, 32'd0);
        manualDone   = 1'b1;
        manualResult = 32'd4;
        step();
        manualDone = 1'b0;
        checkOutput("tie_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("tie_data",  out_data,           32'd4);
        checkOutput("tie_err",   {31'd0, out_err},   32'd0);
        checkOutput("tie_idle",  {31'd0, busy},      32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while waiting on the core with one result queued.
        applyStimulus(32'd0, 32'd7);
        checkOutput("mid_entry", out_data, 32'd7);
        applyStimulus(32'd8, 32'd12);
        step();
        step();
        checkOutput("mid_busy",  {31'd0, busy},      32'd1);
        checkOutput("mid_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_valid",    {31'd0, out_valid}, 32'd0);
        checkOutput("async_data",     out_data,           32'd0);
        checkOutput("async_err",      {31'd0, out_err},   32'd0);
        checkOutput("async_busy",     {31'd0, busy},      32'd0);
        checkOutput("async_start",    {31'd0, start},     32'd0);
        checkOutput("async_opa",      opa,                32'd0);
        checkOutput("async_opb",      opb,                32'd0);
        checkOutput("async_in_ready", {31'd0, in_ready},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        manualDone   = 1'b1;
        manualResult = 32'd4;
        step();
        manualDone = 1'b0;
        checkOutput("late_done_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("late_done_busy",  {31'd0, busy},      32'd0);
        checkOutput("late_done_ready", {31'd0, in_ready},  32'd1);
        step();
        checkOutput("late_done_valid2", {31'd0, out_valid}, 32'd0);
        coreManual = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
